sa_request_gen: RTL and testbench
=================================

Name: sa_request_gen

Overview:
Switch-allocation front end that feeds allocator_top. Each cycle it builds the registered NUM_PORTS x NUM_PORTS request matrix from input-port head flits, per-output credit counters and per-output packet locks. It consumes the allocator's grants to pop input buffers, update credits and locks, and drive registered crossbar selects for switch traversal.

Parameters:
NUM_PORTS, 5, number of router input ports (= output ports); matches allocator NUM_REQS/NUM_RESS
BUF_DEPTH, 4, downstream buffer slots per output; initial and maximum credit count
PORT_W, $clog2(NUM_PORTS), width of a port index (derived; do not override)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
head_valid  input  [NUM_PORTS-1:0]  input port i has a flit at buffer head
head_route  input  [PORT_W-1:0] x NUM_PORTS (unpacked)  output port requested by head flit of input i
head_is_tail  input  [NUM_PORTS-1:0]  head flit of input i is a tail (single-flit packets set this)
credit_return  input  [NUM_PORTS-1:0]  one credit returned to output o this cycle
grants  input  [NUM_PORTS-1:0] x NUM_PORTS (unpacked)  allocator grants, grants[i][o], same shape as allocator
requests  output  [NUM_PORTS-1:0] x NUM_PORTS (unpacked)  registered requests[i][o] to allocator
flit_pop  output  [NUM_PORTS-1:0]  combinational: dequeue head of input i this cycle
xbar_valid  output  [NUM_PORTS-1:0]  registered: output o carries a flit this cycle
xbar_sel  output  [PORT_W-1:0] x NUM_PORTS (unpacked)  registered: input index driving output o
err  output  2  sticky: [0] credit overflow, [1] spurious grant

Behaviour:
- Reset (async, reset==0): requests=0, xbar_valid=0, xbar_sel=0, err=0, all credit counters=BUF_DEPTH, all locks FREE. flit_pop is therefore 0.
- Honoured grant: hg[i][o] = grants[i][o] & requests[i][o]. Any grants[i][o] with requests[i][o]==0 is ignored (no pop, no credit, no lock effect) and sets err[1].
- flit_pop[i] = OR over o of hg[i][o], same cycle as the grant.
- Credit counter per output, width $clog2(BUF_DEPTH+1): cnt_next = cnt - (any hg[*][o]) + credit_return[o].
  - Simultaneous grant and return: net unchanged.
  - If cnt_next would exceed BUF_DEPTH: hold BUF_DEPTH and set err[0].
  - Underflow cannot occur because a request requires a credit.
- Lock FSM per output, states FREE / LOCKED(owner):
  - FREE -> LOCKED(i) on hg[i][o] with head_is_tail[i]==0.
  - LOCKED(i) -> FREE on hg[i][o] with head_is_tail[i]==1.
  - A single-flit packet granted in FREE leaves the lock FREE.
- Request register, updated every edge: requests[i][o] <= head_valid[i] & (head_route[i]==o) & (cnt_next[o]>0) & lock_ok & ~flit_pop[i].
  - lock_ok: lock_next[o]==FREE, or lock_next[o]==LOCKED(i).
  - Result: 1-cycle latency from head_valid to request.
  - An input popped this cycle drops its request for one cycle (stale-flit bubble).
- Multiple inputs may request the same output with only one credit. The allocator grants at most one per output.
- Traversal register: xbar_valid[o] <= any hg[*][o]; xbar_sel[o] <= granting i. Valid 1 cycle after grant. xbar_sel holds its last value when xbar_valid==0.
- err bits clear only on reset.
- Reset asserted mid-packet clears locks and restores credits immediately.

Decomposition:
- Shared package router_pkg holds:
  - port_idx_t (PORT_W bits)
  - credit_t width function
  - lock_state_e {LOCK_FREE, LOCK_HELD}
  - err bit index constants
- Package values derive from VR_define.vh router constants.
- One sub-module, credit_counter: per-output saturating up/down counter with overflow flag, instantiated NUM_PORTS times.
- Lock FSM and request logic stay in sa_request_gen.

Test Plan:
1. Hold reset low 3 cycles then release, no stimulus -> requests all 0, xbar_valid=0, err=0, internal cnt[*]=4.
2. head_valid[0]=1, route=2, tail=1; grant[0][2] when requests[0][2]=1 -> flit_pop[0]=1 that cycle; next cycle xbar_valid[2]=1, xbar_sel[2]=0, cnt[2]=3, requests[0][2]=0 for one cycle.
3. Input 0 streams to out 2 with every request granted, no returns -> exactly 4 grants, then requests[0][2] stays 0. Pulse credit_return[2] -> requests[0][2]=1 next cycle.
4. Input 0 non-tail head to out 1 granted; input 3 head routes to 1 -> requests[3][1]=0 while locked. After input 0 tail is granted, requests[3][1]=1 on the following cycle.
5. cnt[2]=1 with grant[0][2] and credit_return[2] same cycle -> cnt stays 1. With cnt[4]=4 and credit_return[4] -> cnt stays 4, err[0]=1.
6. grants[1][0]=1 while requests[1][0]=0 -> flit_pop[1]=0, xbar_valid[0]=0 next cycle, err[1]=1. Assert reset while out 1 is locked -> lock FREE and err=0 after release.

Source files
------------

// File: rtl/router_pkg.sv
// Router-wide constants and types shared by the switch-allocation front end.
// Defaults mirror the router build constants: 5 ports and 4-deep downstream buffers.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 5;
    localparam int ROUTER_BUF_DEPTH = 4;
    localparam int ROUTER_PORT_W    = $clog2(ROUTER_NUM_PORTS);

    typedef logic [ROUTER_PORT_W-1:0] port_idx_t;

    typedef enum logic [0:0] {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    localparam int ERR_CREDIT_OVF   = 0;
    localparam int ERR_SPURIOUS_GNT = 1;

    // Counter width able to hold 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Per-output credit counter: starts full, decrements on a grant, increments on a return,
// saturates at BUF_DEPTH and flags any attempt to exceed it.
module credit_counter
    import router_pkg::*;
#(
    parameter int  BUF_DEPTH = ROUTER_BUF_DEPTH,
    localparam int CNT_W     = credit_w(BUF_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_next,
    output logic             overflow
);

    localparam logic [CNT_W:0] MAX_EXT = BUF_DEPTH[CNT_W:0];

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W:0]   sum;

    // One extra bit so a return at full credit is visible before saturation.
    always_comb begin
        sum      = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, inc} - {{CNT_W{1'b0}}, dec};
        overflow = (sum > MAX_EXT);
        cnt_next = overflow ? MAX_EXT[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= MAX_EXT[CNT_W-1:0];
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/sa_request_gen.sv
// Switch-allocation front end: builds the registered request matrix from head flits,
// credits and packet locks, and turns honoured grants into pops and crossbar selects.
module sa_request_gen
    import router_pkg::*;
#(
    parameter int  NUM_PORTS = ROUTER_NUM_PORTS,
    parameter int  BUF_DEPTH = ROUTER_BUF_DEPTH,
    localparam int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] head_valid,
    input  logic [PORT_W-1:0]    head_route    [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] head_is_tail,
    input  logic [NUM_PORTS-1:0] credit_return,
    input  logic [NUM_PORTS-1:0] grants        [NUM_PORTS],
    output logic [NUM_PORTS-1:0] requests      [NUM_PORTS],
    output logic [NUM_PORTS-1:0] flit_pop,
    output logic [NUM_PORTS-1:0] xbar_valid,
    output logic [PORT_W-1:0]    xbar_sel      [NUM_PORTS],
    output logic [1:0]           err
);

    localparam int CNT_W = credit_w(BUF_DEPTH);

    logic [NUM_PORTS-1:0] hg        [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_next  [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_hit;
    logic [PORT_W-1:0]    gnt_idx   [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_next  [NUM_PORTS];
    logic [NUM_PORTS-1:0] ovf;
    lock_state_e          lock_reg  [NUM_PORTS];
    lock_state_e          lock_next [NUM_PORTS];
    logic [PORT_W-1:0]    owner_reg [NUM_PORTS];
    logic [PORT_W-1:0]    owner_next[NUM_PORTS];
    logic                 spurious;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
            assign hg[gi]       = grants[gi] & requests[gi];
            assign flit_pop[gi] = |hg[gi];
        end
    endgenerate

    // Grants the allocator issued against a request we never raised are dropped.
    always_comb begin
        spurious = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            spurious = spurious | (|(grants[i] & ~requests[i]));
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_hit[o]    = 1'b0;
            gnt_idx[o]    = '0;
            lock_next[o]  = lock_reg[o];
            owner_next[o] = owner_reg[o];
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (hg[i][o]) begin
                    out_hit[o] = 1'b1;
                    gnt_idx[o] = PORT_W'(i);
                end
            end
            if (out_hit[o]) begin
                if (lock_reg[o] == LOCK_FREE && !head_is_tail[gnt_idx[o]]) begin
                    lock_next[o]  = LOCK_HELD;
                    owner_next[o] = gnt_idx[o];
                end else if (lock_reg[o] == LOCK_HELD && head_is_tail[gnt_idx[o]]) begin
                    lock_next[o] = LOCK_FREE;
                end
            end
        end
    end

    // A popped input drops out for a cycle: its new head is not visible until next cycle.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                req_next[i][o] = head_valid[i]
                               && (head_route[i] == PORT_W'(o))
                               && (cnt_next[o] != '0)
                               && (lock_next[o] == LOCK_FREE || owner_next[o] == PORT_W'(i))
                               && !flit_pop[i];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            credit_counter #(
                .BUF_DEPTH (BUF_DEPTH)
            ) u_credit (
                .clk      (clk),
                .reset    (reset),
                .dec      (out_hit[gi]),
                .inc      (credit_return[gi]),
                .cnt_next (cnt_next[gi]),
                .overflow (ovf[gi])
            );

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lock_reg[gi]   <= LOCK_FREE;
                    owner_reg[gi]  <= '0;
                    requests[gi]   <= '0;
                    xbar_valid[gi] <= 1'b0;
                    xbar_sel[gi]   <= '0;
                end else begin
                    lock_reg[gi]   <= lock_next[gi];
                    owner_reg[gi]  <= owner_next[gi];
                    requests[gi]   <= req_next[gi];
                    xbar_valid[gi] <= out_hit[gi];
                    if (out_hit[gi]) begin
                        xbar_sel[gi] <= gnt_idx[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 2'b00;
        end else begin
            if (|ovf) begin
                err[ERR_CREDIT_OVF] <= 1'b1;
            end
            if (spurious) begin
                err[ERR_SPURIOUS_GNT] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sa_request_gen.sv
// Directed bench for sa_request_gen: request/grant handshakes, credits, locks and errors,
// with crossbar transfers tracked in a scoreboard queue.
module tb_sa_request_gen;

    localparam int NP = 5;
    localparam int PW = 3;

    logic          clk;
    logic          reset;
    logic [NP-1:0] head_valid;
    logic [PW-1:0] head_route [NP];
    logic [NP-1:0] head_is_tail;
    logic [NP-1:0] credit_return;
    logic [NP-1:0] grants     [NP];
    logic [NP-1:0] requests   [NP];
    logic [NP-1:0] flit_pop;
    logic [NP-1:0] xbar_valid;
    logic [PW-1:0] xbar_sel   [NP];
    logic [1:0]    err;

    typedef struct {
        int o;
        int sel;
    } xfer_t;

    xfer_t sb[$];
    int    tests_run = 0;
    int    failed    = 0;
    int    n;

    sa_request_gen #(
        .NUM_PORTS (NP),
        .BUF_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .head_valid    (head_valid),
        .head_route    (head_route),
        .head_is_tail  (head_is_tail),
        .credit_return (credit_return),
        .grants        (grants),
        .requests      (requests),
        .flit_pop      (flit_pop),
        .xbar_valid    (xbar_valid),
        .xbar_sel      (xbar_sel),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] flat_req();
        logic [31:0] f = '0;
        for (int i = 0; i < NP; i++)
            for (int o = 0; o < NP; o++)
                f[i*NP+o] = requests[i][o];
        return f;
    endfunction

    function automatic logic [31:0] rbit(input int i, input int o);
        logic [31:0] f = '0;
        f[i*NP+o] = 1'b1;
        return f;
    endfunction

    task automatic push(input int o, input int sel);
        xfer_t e;
        e.o   = o;
        e.sel = sel;
        sb.push_back(e);
    endtask

    // Advance one edge, then retire every transfer expected from the previous cycle.
    task automatic tick();
        logic [NP-1:0] m;
        xfer_t         got[$];
        @(posedge clk);
        #1;
        m   = '0;
        got = sb;
        sb.delete();
        foreach (got[k]) m[got[k].o] = 1'b1;
        check("xbar_valid", 32'(xbar_valid), 32'(m));
        foreach (got[k])
            check($sformatf("xbar_sel[%0d]", got[k].o), 32'(xbar_sel[got[k].o]), 32'(got[k].sel));
    endtask

    // Allocator model that grants every request (i -> o) it sees, for a bounded cycle count.
    task automatic stream(input int i, input int o, input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            if (requests[i][o]) begin
                grants[i][o] = 1'b1;
                push(o, i);
                cnt++;
            end
            tick();
            grants[i][o] = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b0;
        head_valid    = '0;
        head_is_tail  = '0;
        credit_return = '0;
        for (int i = 0; i < NP; i++) begin
            head_route[i] = '0;
            grants[i]     = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", flat_req(), 32'd0);
        check("rst_xbar_valid", 32'(xbar_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_req", flat_req(), 32'd0);
        check("idle_err", 32'(err), 32'd0);

        // Single-flit packet 0 -> 2
        head_valid[0] = 1'b1; head_route[0] = 3'd2; head_is_tail[0] = 1'b1;
        tick();
        check("t2_req_rise", flat_req(), rbit(0, 2));
        grants[0][2] = 1'b1;
        push(2, 0);
        #1;
        check("t2_flit_pop", 32'(flit_pop), 32'h1);
        tick();
        grants[0][2] = 1'b0;
        check("t2_bubble", flat_req(), 32'd0);
        tick();
        check("t2_req_back", flat_req(), rbit(0, 2));

        // Credit exhaustion on output 2, then a single return
        stream(0, 2, 12, n);
        check("t3_more_grants", 32'(n), 32'd3);
        check("t3_no_credit_req", flat_req(), 32'd0);
        credit_return[2] = 1'b1;
        tick();
        credit_return[2] = 1'b0;
        check("t3_return_req", flat_req(), rbit(0, 2));

        // Grant and return in the same cycle leave credit at 1
        grants[0][2] = 1'b1; credit_return[2] = 1'b1;
        push(2, 0);
        tick();
        grants[0][2] = 1'b0; credit_return[2] = 1'b0;
        check("t5_same_cycle_bubble", flat_req(), 32'd0);
        tick();
        check("t5_cnt_held", flat_req(), rbit(0, 2));
        head_valid[0] = 1'b0;
        tick();
        check("t5_idle", flat_req(), 32'd0);

        // Packet lock on output 1: input 0 multi-flit, input 3 waits
        head_valid[0] = 1'b1; head_route[0] = 3'd1; head_is_tail[0] = 1'b0;
        head_valid[3] = 1'b1; head_route[3] = 3'd1; head_is_tail[3] = 1'b0;
        tick();
        check("t4_both_req", flat_req(), rbit(0, 1) | rbit(3, 1));
        grants[0][1] = 1'b1;
        push(1, 0);
        tick();
        grants[0][1] = 1'b0;
        check("t4_locked_bubble", flat_req(), 32'd0);
        tick();
        check("t4_owner_only", flat_req(), rbit(0, 1));
        head_is_tail[0] = 1'b1;
        grants[0][1] = 1'b1;
        push(1, 0);
        tick();
        grants[0][1] = 1'b0;
        head_valid[0] = 1'b0; head_valid[3] = 1'b0;
        check("t4_unlock_req", flat_req(), rbit(3, 1));
        tick();
        check("t4_idle", flat_req(), 32'd0);

        // Restore outputs 1 and 2 to full credit without overflowing
        credit_return = 5'b00110;
        tick();
        tick();
        credit_return = 5'b00100;
        tick();
        credit_return = '0;
        check("restore_err", 32'(err), 32'd0);

        // Return at full credit on output 4
        credit_return[4] = 1'b1;
        tick();
        credit_return[4] = 1'b0;
        check("t5_overflow_err", 32'(err), 32'h1);
        head_valid[2] = 1'b1; head_route[2] = 3'd4; head_is_tail[2] = 1'b1;
        tick();
        stream(2, 4, 12, n);
        check("t5_saturated_grants", 32'(n), 32'd4);
        head_valid[2] = 1'b0;
        tick();

        // Spurious grant
        grants[1][0] = 1'b1;
        #1;
        check("t6_spurious_pop", 32'(flit_pop), 32'd0);
        tick();
        grants[1][0] = 1'b0;
        check("t6_spurious_err", 32'(err), 32'h3);

        // Reset while output 1 is locked by input 1
        head_valid[1] = 1'b1; head_route[1] = 3'd1; head_is_tail[1] = 1'b0;
        tick();
        check("t6_lock_req", flat_req(), rbit(1, 1));
        grants[1][1] = 1'b1;
        push(1, 1);
        tick();
        grants[1][1] = 1'b0;
        head_valid[1] = 1'b0;
        head_valid[4] = 1'b1; head_route[4] = 3'd1; head_is_tail[4] = 1'b1;
        tick();
        check("t6_blocked_by_lock", flat_req(), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_async_err", 32'(err), 32'd0);
        check("t6_async_xbar", 32'(xbar_valid), 32'd0);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_lock_freed", flat_req(), rbit(4, 1));
        check("t6_err_after_reset", 32'(err), 32'd0);
        head_valid[4] = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
